// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory-bus and status signals of the IF/DM memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_f;
  logic              stall_m;
  logic              busy;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m, busy
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between fetch and data ports with bounded DM priority
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t        state, state_nx;
  logic          own_dm, we_r, grant, grant_dm, streak_max;
  logic [SW-1:0] streak;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // grant decision and next state; DM wins contention until its streak saturates
  always_comb begin
    streak_max = streak == SW'(MAX_DM_STREAK);
    grant      = state == IDLE && (bus.if_req || bus.dm_req);
    grant_dm   = bus.dm_req && !(bus.if_req && streak_max);
    state_nx   = state == IDLE ? (grant ? BUSY : IDLE) :
                 state == BUSY ? (bus.mem_ready ? RESP : BUSY) : IDLE;
  end
  // bus registers latched at grant, read data captured on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      own_dm        <= 1'b0;
      we_r          <= 1'b0;
      streak        <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      if (grant) begin
        own_dm        <= grant_dm;
        we_r          <= grant_dm && bus.dm_we;
        bus.mem_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata <= grant_dm ? bus.dm_wdata : '0;
        streak        <= grant_dm && bus.if_req ? (streak_max ? streak : streak + SW'(1)) : '0;
      end
      if (state == BUSY && bus.mem_ready && !own_dm) bus.if_rdata <= bus.mem_rdata;
      if (state == BUSY && bus.mem_ready && own_dm && !we_r) bus.dm_rdata <= bus.mem_rdata;
    end
  end
  assign bus.mem_req = state == BUSY;
  assign bus.mem_we  = state == BUSY && we_r;
  assign bus.if_ack  = state == RESP && !own_dm;
  assign bus.dm_ack  = state == RESP && own_dm;
  assign bus.busy    = state != IDLE;
  assign bus.stall_f = bus.if_req && !bus.if_ack;
  assign bus.stall_m = bus.dm_req && !bus.dm_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner-case sequences and randomized run against a transaction model
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic rst, ifr; logic [31:0] ifa; logic dr, dw; logic [31:0] da, dd; logic rdy; logic [31:0] rd;
    logic e_req, e_we; logic [31:0] e_addr, e_wd; logic e_iack, e_dack, e_busy; logic [31:0] e_ird, e_drd;
  } vec_t;
  vec_t vt [11];

  bit          m_act, m_resp, m_dm, m_we;
  int          m_streak;
  logic [31:0] m_addr, m_wd, m_ird, m_drd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive_in(input logic r, ifr, input logic [31:0] ifa, input logic dr, dw,
                          input logic [31:0] da, dd, input logic rdy, input logic [31:0] rd);
    rst = r; bus.if_req = ifr; bus.if_addr = ifa; bus.dm_req = dr; bus.dm_we = dw;
    bus.dm_addr = da; bus.dm_wdata = dd; bus.mem_ready = rdy; bus.mem_rdata = rd;
  endtask

  task automatic do_reset();
    drive_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // advance the reference model by one rising edge using the inputs that edge sampled
  task automatic model_step();
    bit want_if, want_dm;
    want_if = bus.if_req; want_dm = bus.dm_req;
    if (rst) begin
      m_act = 0; m_resp = 0; m_dm = 0; m_we = 0; m_streak = 0;
      m_addr = 0; m_wd = 0; m_ird = 0; m_drd = 0;
    end else if (m_resp) m_resp = 0;
    else if (m_act) begin
      if (bus.mem_ready) begin
        if (!m_dm) m_ird = bus.mem_rdata;
        else if (!m_we) m_drd = bus.mem_rdata;
        m_act = 0; m_resp = 1;
      end
    end else if (want_if || want_dm) begin
      m_dm     = want_dm && !(want_if && m_streak == MAXS);
      m_streak = (m_dm && want_if) ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      m_addr   = m_dm ? bus.dm_addr : bus.if_addr;
      m_we     = m_dm && bus.dm_we;
      m_wd     = m_dm ? bus.dm_wdata : 32'h0;
      m_act    = 1;
    end
  endtask

  initial begin
    int g_cnt, r_cnt, a_cnt;
    bit prev, dm_order [10];
    logic [31:0] seen_addr;
    drive_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[0]  = '{1,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,0};
    vt[1]  = '{1,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,0};
    vt[2]  = '{0,1,32'h10,0,0,0,0,0,0,                    1,0,32'h10,0,0,0,1,0,0};
    vt[3]  = '{0,1,32'h10,0,0,0,0,1,32'h00500093,         0,0,32'h10,0,1,0,1,32'h00500093,0};
    vt[4]  = '{0,0,0,0,0,0,0,0,0,                         0,0,32'h10,0,0,0,0,32'h00500093,0};
    vt[5]  = '{0,0,0,1,1,32'h40,32'hDEADBEEF,0,0,         1,1,32'h40,32'hDEADBEEF,0,0,1,32'h00500093,0};
    vt[6]  = '{0,0,0,1,1,32'h40,32'hDEADBEEF,0,0,         1,1,32'h40,32'hDEADBEEF,0,0,1,32'h00500093,0};
    vt[7]  = '{0,0,0,1,1,32'h40,32'hDEADBEEF,0,0,         1,1,32'h40,32'hDEADBEEF,0,0,1,32'h00500093,0};
    vt[8]  = '{0,0,0,1,1,32'h40,32'hDEADBEEF,0,0,         1,1,32'h40,32'hDEADBEEF,0,0,1,32'h00500093,0};
    vt[9]  = '{0,0,0,1,1,32'h40,32'hDEADBEEF,1,32'h12345678, 0,0,32'h40,32'hDEADBEEF,0,1,1,32'h00500093,0};
    vt[10] = '{0,0,0,0,0,0,0,0,0,                         0,0,32'h40,32'hDEADBEEF,0,0,0,32'h00500093,0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.busy, bus.stall_f, bus.stall_m}, 0);
      chk("idle_bus_regs", bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.dm_rdata, 0);
    end
    for (int i = 0; i < 11; i++) begin
      drive_in(vt[i].rst, vt[i].ifr, vt[i].ifa, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd, vt[i].rdy, vt[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), bus.mem_req, vt[i].e_req);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, vt[i].e_we);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vt[i].e_wd);
      chk($sformatf("v%0d_if_ack", i), bus.if_ack, vt[i].e_iack);
      chk($sformatf("v%0d_dm_ack", i), bus.dm_ack, vt[i].e_dack);
      chk($sformatf("v%0d_busy", i), bus.busy, vt[i].e_busy);
      chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, vt[i].e_ird);
      chk($sformatf("v%0d_dm_rdata", i), bus.dm_rdata, vt[i].e_drd);
      chk($sformatf("v%0d_stall_f", i), bus.stall_f, vt[i].ifr & ~vt[i].e_iack);
      chk($sformatf("v%0d_stall_m", i), bus.stall_m, vt[i].dr & ~vt[i].e_dack);
    end

    do_reset();
    drive_in(0, 1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h0BADF00D);
    g_cnt = 0; prev = 0;
    for (int c = 0; c < 80 && g_cnt < 10; c++) begin
      @(negedge clk);
      if (bus.if_ack && bus.dm_ack) chk("contention_dual_ack", 1, 0);
      if (bus.mem_req && !prev) begin
        dm_order[g_cnt] = bus.mem_addr == 32'h200;
        g_cnt++;
      end
      prev = bus.mem_req;
    end
    chk("contention_grant_count", g_cnt, 10);
    for (int i = 0; i < g_cnt; i++) chk($sformatf("contention_grant%0d_is_dm", i), dm_order[i], (i % 5) != 4);

    do_reset();
    drive_in(0, 1, 32'h30, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10 && !bus.mem_req; c++) @(negedge clk);
    chk("midreset_reached_busy", bus.mem_req, 1);
    rst = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    chk("midreset_mem_req", bus.mem_req, 0);
    chk("midreset_busy", bus.busy, 0);
    rst = 1'b0; bus.mem_ready = 1'b1;
    a_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_cnt += int'(bus.if_ack) + int'(bus.dm_ack) + int'(bus.busy);
    end
    chk("midreset_no_ack_no_busy", a_cnt, 0);

    do_reset();
    drive_in(0, 1, 32'h20, 0, 0, 0, 0, 1, 32'h00A00113);
    @(negedge clk);
    bus.if_req = 1'b0;
    r_cnt = 0; a_cnt = 0; prev = 0; seen_addr = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.mem_req && !prev) begin r_cnt++; seen_addr = bus.mem_addr; end
      prev = bus.mem_req;
      a_cnt += int'(bus.if_ack);
      @(negedge clk);
    end
    chk("dropped_req_accesses", r_cnt, 1);
    chk("dropped_req_addr", seen_addr, 32'h20);
    chk("dropped_req_acks", a_cnt, 1);
    chk("dropped_req_rdata", bus.if_rdata, 32'h00A00113);

    drive_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      model_step();
      chk("rnd_mem_req", bus.mem_req, m_act);
      chk("rnd_busy", bus.busy, m_act | m_resp);
      chk("rnd_if_ack", bus.if_ack, m_resp & !m_dm);
      chk("rnd_dm_ack", bus.dm_ack, m_resp & m_dm);
      chk("rnd_if_rdata", bus.if_rdata, m_ird);
      chk("rnd_dm_rdata", bus.dm_rdata, m_drd);
      chk("rnd_stall_f", bus.stall_f, bus.if_req & !(m_resp & !m_dm));
      chk("rnd_stall_m", bus.stall_m, bus.dm_req & (m_resp ? !m_dm : 1'b1));
      if (m_act) begin
        chk("rnd_mem_addr", bus.mem_addr, m_addr);
        chk("rnd_mem_we", bus.mem_we, m_we);
        chk("rnd_mem_wdata", bus.mem_wdata, m_wd);
      end
      if (bus.if_ack || !bus.if_req) begin
        bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = $urandom;
      end
      if (bus.dm_ack || !bus.dm_req) begin
        bus.dm_req = 1'($urandom_range(0, 1)); bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
      end
      rst = $urandom_range(0, 299) == 0;
      bus.mem_ready = $urandom_range(0, 2) == 0;
      bus.mem_rdata = $urandom;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between the instruction-fetch port (IF) and the data-memory port (DM) of the 5-stage core.
- Sits between the fetch/memory-access stages and the unified memory.
- Sequences each access as request, wait-for-ready, then registered response.
- Produces stall signals the pipeline uses to freeze the fetch and memory stages.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is pending before IF is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid when dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for data.
- mem_req  out  1  bus request to memory.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_rdata  in  DATA_W  bus read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- stall_f  out  1  if_req & ~if_ack (combinational).
- stall_m  out  1  dm_req & ~dm_ack (combinational).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Single clock (clk); rst synchronous, active-high. All state changes on the rising edge of clk.
- Reset (also mid-transaction, overriding any in-flight access):
  - FSM returns to IDLE, abandoning any in-flight access with no ack.
  - mem_req, mem_we, if_ack, dm_ack, busy = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Streak counter = 0; owner = IF.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise pick the owner:
    - Only IF pending: IF.
    - Only DM pending: DM.
    - Both pending: DM, unless streak == MAX_DM_STREAK, then IF.
  - Latch the owner's addr, we (0 for IF) and wdata into the bus registers; go to BUSY.
- BUSY:
  - mem_req=1; bus signals driven from the latched registers and held stable.
  - mem_ready=0: stay in BUSY, with no timeout.
  - mem_ready=1: capture mem_rdata into the owner's rdata register, loads and fetches only. A store leaves dm_rdata unchanged.
  - On mem_ready=1, go to RESP; mem_req drops the next cycle.
- RESP:
  - The owner's ack=1 for exactly this cycle; the other port's ack=0.
  - Requests are not sampled; return to IDLE.
- Latency: req seen in IDLE at cycle N gives mem_req at N+1. mem_ready at N+1+W gives ack at N+2+W. Minimum 3 cycles per access; back-to-back throughput is one access per 3 cycles at W=0.
- Streak counter, updated at the grant in IDLE:
  - DM grant increments it, saturating at MAX_DM_STREAK.
  - IF grant clears it to 0.
  - A DM grant with no IF pending also clears it; fairness applies only to contention.
- Input rules:
  - Requester inputs are sampled only in IDLE; changes during BUSY/RESP are ignored.
  - Dropping req before ack does not cancel the access; the ack still pulses.
  - A req held high through the RESP cycle is treated as a new request in the following IDLE.
- rdata registers hold their value until the next completed read for that port.
- Both acks are never high in the same cycle. mem_req is never high outside BUSY.

Test Plan:
- Reset/idle: assert rst 2 cycles, then release with no requests. All outputs 0, busy=0, for 10 cycles.
- Single fetch, zero wait: if_req=1, if_addr=0x10, mem_ready=1 in the first BUSY cycle with mem_rdata=0x00500093.
  - Required: mem_req for 1 cycle with mem_addr=0x10 and mem_we=0.
  - Required: if_ack pulses 2 cycles after the request is seen, with if_rdata=0x00500093. stall_f=1 until then.
- Store with waits: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles.
  - Required: mem_req held 4 cycles with stable addr, wdata and we=1.
  - Required: dm_ack one cycle later; dm_rdata unchanged.
- Contention/fairness: if_req and dm_req held high continuously, MAX_DM_STREAK=4, mem_ready always 1. Grant order must be DM,DM,DM,DM,IF, then repeating.
- Reset mid-access: rst asserted while in BUSY with mem_ready=0. Next cycle mem_req=0, no ack ever pulses, FSM in IDLE.
- Request dropped early: if_req pulsed 1 cycle in IDLE with addr 0x20. The access still completes and if_ack pulses once; no second access is issued.
